prog_ctrl: RTL
==============

PROG_CTRL -- requirements
Module: prog_ctrl

Interface
REQ-001 Parameter Psize, default 4: program memory address width.
REQ-002 Parameter Isize, default 20: instruction word width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ld_valid  in  1  loader offers an instruction word.
REQ-006 ld_data  in  Isize  instruction word to store.
REQ-007 ld_ready  out  1  controller accepts the loader word this cycle.
REQ-008 ld_done  in  1  loader image complete.
REQ-009 run  in  1  start or resume execution.
REQ-010 stall  in  1  CPU holds the PC.
REQ-011 branch  in  1  CPU takes a branch; branch_target  in  Psize  destination.
REQ-012 halt_req  in  1  CPU requests halt.
REQ-013 mem_addr  out  Psize; mem_we  out  1; mem_wdata  out  Isize  program memory port.
REQ-014 pc  out  Psize  current fetch address; cpu_en  out  1  fetched instruction is valid to execute.
REQ-015 state  out  2  IDLE=00, LOAD=01, RUN=10, HALT=11.
REQ-016 load_full  out  1  sticky: last address written.

Function
REQ-017 Handshake: a word is accepted when ld_valid && ld_ready; mem_we = that term, combinational; mem_wdata = ld_data.
REQ-018 ld_ready = (state IDLE or LOAD) && !load_full.
REQ-019 Each accepted word is written at write pointer wptr; wptr increments by 1 the next cycle.
REQ-020 Word accepted at wptr = 2^Psize-1 sets load_full; wptr does not wrap; further ld_valid is not accepted.
REQ-021 mem_addr = wptr in IDLE/LOAD, = pc in RUN/HALT.
REQ-022 IDLE: accepted word -> LOAD; run (no accepted word) -> RUN with pc = 0; both together -> LOAD, run ignored.
REQ-023 LOAD: ld_done -> IDLE next cycle; word accepted in the same cycle as ld_done is written; run is ignored.
REQ-024 RUN: cpu_en = 1; program memory read is combinational, so the instruction at pc is valid in the same cycle.
REQ-025 RUN next pc priority: halt_req (hold, -> HALT) > stall (hold) > branch (pc = branch_target) > pc+1 modulo 2^Psize.
REQ-026 pc = 2^Psize-1 with no stall/branch/halt wraps to 0.
REQ-027 HALT: cpu_en = 0; pc held; run -> RUN resuming at held pc; ld_valid, branch, stall ignored; ld_ready = 0.
REQ-028 Only reset leaves HALT toward IDLE; reloading requires reset.

Reset
REQ-029 On reset: state = IDLE, pc = 0, wptr = 0, load_full = 0, cpu_en = 0, ld_ready = 1, mem_we = 0.
REQ-030 Reset overrides all inputs in the same cycle, including mid-load and mid-run; a word offered during reset is not written.

Configuration
REQ-031 Macro PROG_CTRL_SINGLE_STEP_EN.
REQ-032 Defined: extra input step (1 bit); step in HALT asserts cpu_en for exactly one cycle, pc advances per REQ-025 (halt_req ignored), then returns to HALT; run has priority over step.
REQ-033 Undefined: step port absent; HALT behaves per REQ-027.

Structure
REQ-034 Package prog_pkg holds ctrl_state_t enum (IDLE, LOAD, RUN, HALT, 2-bit encoding per REQ-015) and default PSIZE/ISIZE constants.
REQ-035 Sub-module prog_pc implements pc register and next-pc priority mux (REQ-025/026); FSM, wptr and load logic stay in prog_ctrl.

Verification
REQ-036 Reset, then 3 ld_valid words 0x00001,0x00002,0x00003 and ld_done -> writes at addr 0,1,2, state 01 then 00, wptr = 3.
REQ-037 Load 16 words (Psize=4) with ld_valid held for 17 cycles -> load_full = 1 after 16th, ld_ready = 0, 17th not written.
REQ-038 run in IDLE, no stall -> pc 0,1,...,15,0 with cpu_en = 1; branch to 0x9 at pc=3 -> next pc 0x9; stall+branch together -> pc held.
REQ-039 halt_req with branch at pc=5 -> state 11, pc = 5, cpu_en = 0; run -> RUN at pc = 5.
REQ-040 reset asserted mid-LOAD with ld_valid = 1 -> no write, state 00, wptr = 0, load_full = 0.
REQ-041 With PROG_CTRL_SINGLE_STEP_EN, HALT at pc=7, step pulse -> one cycle cpu_en = 1, pc = 8, state back to 11.

Source files
------------

// File: rtl/prog_pkg.sv
// prog_pkg -- shared types and defaults for the program-memory controller.
//
// Contents:
//   PSIZE, ISIZE   default program address width and instruction word width
//   ctrl_state_t   controller state, encoded IDLE=00 LOAD=01 RUN=10 HALT=11
//   is_load_phase  true in the two states where the loader owns the memory port
package prog_pkg;

    localparam int PSIZE = 4;
    localparam int ISIZE = 20;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } ctrl_state_t;

    function automatic logic is_load_phase(input ctrl_state_t s);
        return (s == IDLE) || (s == LOAD);
    endfunction

endpackage

// File: rtl/prog_pc.sv
// prog_pc -- program counter register with next-pc priority mux.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset (pc -> 0)
//   clear          force pc to 0 on the next edge (entry into execution)
//   advance        this cycle executes an instruction, so pc may move
//   halt_req       hold pc (halt has top priority)
//   stall          hold pc
//   branch         load branch_target
//   branch_target  destination address
//   pc             current fetch address
//
// When advance is set the priority is halt_req > stall > branch > pc+1,
// and pc+1 wraps naturally at 2^Psize.
module prog_pc
    import prog_pkg::*;
#(
    parameter int Psize = PSIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             branch,
    input  logic [Psize-1:0] branch_target,
    output logic [Psize-1:0] pc
);

    logic [Psize-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (clear) begin
            pc_next = '0;
        end else if (advance) begin
            if (halt_req) begin
                pc_next = pc;
            end else if (stall) begin
                pc_next = pc;
            end else if (branch) begin
                pc_next = branch_target;
            end else begin
                pc_next = pc + Psize'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/prog_ctrl.sv
// prog_ctrl -- program loader / execution controller for a small CPU.
//
// A loader streams instruction words into program memory through a
// valid/ready handshake; afterwards the controller sequences the fetch
// address (pc) for the CPU, honouring stall, branch and halt requests.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ld_valid, ld_data   loader word offer
//   ld_ready            controller accepts the offered word this cycle
//   ld_done             loader image complete
//   run                 start (from IDLE) or resume (from HALT) execution
//   stall, branch,
//   branch_target,
//   halt_req            CPU control of the fetch address
//   step                single-step request in HALT (only with the macro)
//   mem_addr, mem_we,
//   mem_wdata           program memory port (write pointer while loading,
//                       pc while running)
//   pc, cpu_en          fetch address and "instruction valid to execute"
//   state               IDLE=00 LOAD=01 RUN=10 HALT=11
//   load_full           sticky: last memory address has been written
//
// Build option:
//   PROG_CTRL_SINGLE_STEP_EN  adds the step input; a step pulse in HALT
//                             executes exactly one instruction and returns
//                             to HALT (run takes priority over step).
module prog_ctrl
    import prog_pkg::*;
#(
    parameter int Psize = PSIZE,
    parameter int Isize = ISIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    input  logic [Isize-1:0] ld_data,
    output logic             ld_ready,
    input  logic             ld_done,
    input  logic             run,
    input  logic             stall,
    input  logic             branch,
    input  logic [Psize-1:0] branch_target,
    input  logic             halt_req,
`ifdef PROG_CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [Psize-1:0] mem_addr,
    output logic             mem_we,
    output logic [Isize-1:0] mem_wdata,
    output logic [Psize-1:0] pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             load_full
);

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [Psize-1:0] wptr;
    logic             accept;
    logic             last_addr;
    logic             step_active;
    logic             pc_clear;
    logic             pc_advance;
    logic             pc_halt;

    assign state     = state_q;
    assign ld_ready  = is_load_phase(state_q) && !load_full;
    // Reset wins over a word offered in the same cycle: it must not be written.
    assign accept    = ld_valid && ld_ready && !reset;
    assign mem_we    = accept;
    assign mem_wdata = ld_data;
    assign last_addr = (wptr == {Psize{1'b1}});

    // Write pointer saturates on the last address; load_full then closes
    // the handshake until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            load_full <= 1'b0;
        end else if (accept) begin
            if (last_addr) begin
                load_full <= 1'b1;
            end else begin
                wptr <= wptr + Psize'(1);
            end
        end
    end

`ifdef PROG_CTRL_SINGLE_STEP_EN
    // One-cycle execute window opened by a step request while halted.
    // Cleared after one cycle so a single pulse executes one instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_active <= 1'b0;
        end else begin
            step_active <= (state_q == HALT) && !step_active && step && !run;
        end
    end
`else
    assign step_active = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_clear   = 1'b0;
        pc_advance = 1'b0;
        pc_halt    = 1'b0;
        cpu_en     = 1'b0;
        mem_addr   = pc;
        unique case (state_q)
            IDLE: begin
                mem_addr = wptr;
                // An accepted word takes precedence over run.
                if (accept) begin
                    state_d = LOAD;
                end else if (run) begin
                    state_d  = RUN;
                    pc_clear = 1'b1;
                end
            end
            LOAD: begin
                mem_addr = wptr;
                if (ld_done) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cpu_en     = 1'b1;
                pc_advance = 1'b1;
                pc_halt    = halt_req;
                if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // During a single step halt_req is deliberately not forwarded.
                if (step_active) begin
                    cpu_en     = 1'b1;
                    pc_advance = 1'b1;
                end
                if (run) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    prog_pc #(
        .Psize(Psize)
    ) u_pc (
        .clk          (clk),
        .reset        (reset),
        .clear        (pc_clear),
        .advance      (pc_advance),
        .halt_req     (pc_halt),
        .stall        (stall),
        .branch       (branch),
        .branch_target(branch_target),
        .pc           (pc)
    );

endmodule
